aes_round_sequencer: RTL and testbench
======================================

# aes_round_sequencer

Round-level controller for the AES-128 encryption datapath. It accepts a plaintext block and cipher key over a start/ready handshake, fetches each of the 11 round keys from the key-expansion unit, and drives the single-round stage block through round 0 (AddRoundKey only), rounds 1–9 and the final round. After each round it captures the stage result and feeds it back as the next round's input, then presents the ciphertext with a one-cycle done pulse. It sits between the crypto-extension issue logic and the round-stage datapath.

## Interface
- NR, 10, index of the final round; round counter spans 0..NR
- TIMEOUT, 63, watchdog limit in stage cycles (used only with AES_SEQ_TIMEOUT_EN)

- clk_i  in  1  clock
- rst_i  in  1  synchronous, active-high reset
- start_i  in  1  request to encrypt; accepted when start_i & ready_o
- plaintext_i  in  128  block, sampled on accept
- ready_o  out  1  sequencer idle, can accept start
- busy_o  out  1  encryption in progress
- done_o  out  1  one-cycle pulse, ciphertext_o valid
- ciphertext_o  out  128  result, held until next accept
- abort_i  in  1  cancel current operation
- err_o  out  1  sticky watchdog error (only with AES_SEQ_TIMEOUT_EN; otherwise tied 0)
- rk_req_o  out  1  round-key request
- rk_idx_o  out  4  round index being requested
- rk_valid_i  in  1  rk_i valid for rk_idx_o
- rk_i  in  128  round key
- stage_en_o  out  1  stage FSM enable
- stage_hold_o  out  1  stage clock/reset qualifier
- stage_rst_n_o  out  1  active-low reset to stage
- zero_round_o  out  1  current round is round 0
- final_round_o  out  1  current round is NR
- stage_state_o  out  128  round input state
- stage_key_o  out  128  round key
- stage_done_i  in  1  stage signals round complete
- stage_state_i  in  128  stage result; valid the cycle after stage_done_i

## Operation
- States: IDLE, KEYREQ, ROUND, CAPTURE, DONE.
- IDLE: ready_o=1. On start_i: state_reg<=plaintext_i, round<=0, go KEYREQ.
- KEYREQ: rk_req_o=1, rk_idx_o=round. On rk_valid_i: key_reg<=rk_i, go ROUND. Wait indefinitely otherwise.
- ROUND: stage_en_o=1, stage_hold_o=1; stage_state_o=state_reg, stage_key_o=key_reg; zero_round_o=(round==0), final_round_o=(round==NR). On stage_done_i go CAPTURE.
- CAPTURE (1 cycle): stage_hold_o=1, stage_en_o=0; state_reg<=stage_state_i. If round==NR go DONE, else round<=round+1, go KEYREQ.
- DONE (1 cycle): done_o=1, ciphertext_o<=state_reg (visible from this cycle), go IDLE.
- busy_o = state≠IDLE. start_i while busy ignored.
- abort_i in any non-IDLE state: next state IDLE, no done_o, ciphertext_o unchanged, stage_rst_n_o=0 for exactly the next cycle. Abort with start_i in IDLE: start ignored.
- abort_i wins over rk_valid_i, stage_done_i and the CAPTURE→DONE transition.
- Round counter 4 bits; never exceeds NR.

## Timing
- Reset (rst_i=1 at a clock edge): state IDLE, round 0, ready_o=1, busy_o=0, done_o=0, ciphertext_o=0, err_o=0, rk_req_o=0, stage_en_o=0, stage_hold_o=0, zero_round_o=0, final_round_o=0, stage_state_o=0, stage_key_o=0; stage_rst_n_o=0 while rst_i high and for the cycle after.
- All outputs registered or decoded from registered state; no input→output combinational path except none.
- With rk_valid_i constant 1 and stage_done_i arriving in the Dth ROUND cycle: round period D+2 cycles; done_o asserts 11·(D+2)+1 cycles after the accept cycle.
- rk_req_o holds steady with rk_idx_o until rk_valid_i; handshake completes in the same cycle.
- Reset mid-operation: behaves as reset from any state; no done_o.

## Configuration
- AES_SEQ_TIMEOUT_EN defined: 6-bit counter clears on ROUND entry, increments each ROUND cycle; reaching TIMEOUT without stage_done_i sets err_o (sticky until rst_i or next accept) and acts as abort (IDLE, stage_rst_n_o pulse).
- Undefined: no counter; ROUND waits indefinitely; err_o constant 0.

## Test plan
- FIPS-197 C.1 vector: key 000102…0f, plaintext 00112233…ff, behavioural stage with D=4 -> done_o at accept+67 cycles, ciphertext_o=69c4e0d86a7b0430d8cdb78070b4c55a.
- rk_valid_i delayed 3 cycles per round -> rk_idx_o steps 0..10 in order, rk_req_o stable while waiting, same ciphertext, done delayed by 33 cycles.
- start_i pulsed during round 5 -> ignored, one done_o only; start_i with abort_i in IDLE -> remains IDLE.
- abort_i asserted in CAPTURE of round 10 -> no done_o, ciphertext_o keeps previous value, stage_rst_n_o low one cycle, ready_o=1 next cycle.
- rst_i asserted in ROUND of round 3 -> all outputs at reset values next cycle; new start completes correctly.
- AES_SEQ_TIMEOUT_EN defined, stage_done_i never asserted -> err_o=1 after 63 ROUND cycles, state IDLE; undefined -> busy_o stays 1.

Source files
------------

// File: rtl/aes_round_sequencer.sv
// AES-128 round-level sequencer: key fetch, stage drive and feedback per round.
// Optional stage watchdog enabled by defining AES_SEQ_TIMEOUT_EN.
module aes_round_sequencer #(
  parameter int unsigned NR      = 10,
  parameter int unsigned TIMEOUT = 63
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         start_i,
  input  logic [127:0] plaintext_i,
  output logic         ready_o,
  output logic         busy_o,
  output logic         done_o,
  output logic [127:0] ciphertext_o,
  input  logic         abort_i,
  output logic         err_o,
  output logic         rk_req_o,
  output logic [3:0]   rk_idx_o,
  input  logic         rk_valid_i,
  input  logic [127:0] rk_i,
  output logic         stage_en_o,
  output logic         stage_hold_o,
  output logic         stage_rst_n_o,
  output logic         zero_round_o,
  output logic         final_round_o,
  output logic [127:0] stage_state_o,
  output logic [127:0] stage_key_o,
  input  logic         stage_done_i,
  input  logic [127:0] stage_state_i
);

  typedef enum logic [2:0] {
    IDLE, KEYREQ, ROUND, CAPTURE, DONE
  } st_e;

  localparam logic [3:0] NR_C = 4'(NR);

  st_e          st_q, st_d;
  logic [3:0]   round_q, round_d;
  logic [127:0] blk_q, blk_d;
  logic [127:0] key_q, key_d;
  logic [127:0] ct_q, ct_d;
  logic         srst_q, srst_d;
  logic         err_q, err_d;
  logic         accept, kill, tmo;

`ifdef AES_SEQ_TIMEOUT_EN
  localparam logic [5:0] TMO_LAST = 6'(TIMEOUT - 1);
  logic [5:0] wd_q, wd_d;

  // counter sits at zero outside ROUND, so it restarts on every entry
  always_comb begin
    wd_d = '0;
    tmo  = 1'b0;
    if (st_q == ROUND) begin
      wd_d = wd_q + 6'd1;
      tmo  = !stage_done_i && (wd_q == TMO_LAST);
    end
  end
`else
  logic unused_tmo;
  assign unused_tmo = (TIMEOUT == 0);
  assign tmo = 1'b0;
`endif

  always_comb begin
    st_d    = st_q;
    round_d = round_q;
    blk_d   = blk_q;
    key_d   = key_q;
    ct_d    = ct_q;
    err_d   = err_q;
    accept  = (st_q == IDLE) && start_i && !abort_i;
    kill    = (st_q != IDLE) && (abort_i || tmo);
    srst_d  = kill;
    unique case (st_q)
      IDLE: begin
        if (accept) begin
          blk_d   = plaintext_i;
          round_d = '0;
          err_d   = 1'b0;
          st_d    = KEYREQ;
        end
      end
      KEYREQ: begin
        if (rk_valid_i) begin
          key_d = rk_i;
          st_d  = ROUND;
        end
      end
      ROUND: begin
        if (stage_done_i) st_d = CAPTURE;
      end
      CAPTURE: begin
        blk_d = stage_state_i;
        if (round_q == NR_C) begin
          ct_d = stage_state_i;
          st_d = DONE;
        end else begin
          round_d = round_q + 4'd1;
          st_d    = KEYREQ;
        end
      end
      DONE: st_d = IDLE;
      default: st_d = IDLE;
    endcase
    if (kill) begin
      st_d = IDLE;
      ct_d = ct_q;
    end
    if (tmo) err_d = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      st_q    <= IDLE;
      round_q <= '0;
      blk_q   <= '0;
      key_q   <= '0;
      ct_q    <= '0;
      srst_q  <= 1'b1;
      err_q   <= 1'b0;
`ifdef AES_SEQ_TIMEOUT_EN
      wd_q    <= '0;
`endif
    end else begin
      st_q    <= st_d;
      round_q <= round_d;
      blk_q   <= blk_d;
      key_q   <= key_d;
      ct_q    <= ct_d;
      srst_q  <= srst_d;
      err_q   <= err_d;
`ifdef AES_SEQ_TIMEOUT_EN
      wd_q    <= wd_d;
`endif
    end
  end

  assign ready_o       = (st_q == IDLE);
  assign busy_o        = (st_q != IDLE);
  assign done_o        = (st_q == DONE);
  assign ciphertext_o  = ct_q;
  assign err_o         = err_q;
  assign rk_req_o      = (st_q == KEYREQ);
  assign rk_idx_o      = round_q;
  assign stage_en_o    = (st_q == ROUND);
  assign stage_hold_o  = (st_q == ROUND) || (st_q == CAPTURE);
  assign stage_rst_n_o = ~srst_q;
  assign zero_round_o  = (st_q == ROUND) && (round_q == 4'd0);
  assign final_round_o = (st_q == ROUND) && (round_q == NR_C);
  assign stage_state_o = blk_q;
  assign stage_key_o   = key_q;

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Bench for aes_round_sequencer: behavioural AES stage and key unit,
// FIPS-197 C.1 vector, key stalls, ignored starts, abort, reset, watchdog.
module tb_aes_round_sequencer;

  logic         clk = 1'b0;
  logic         rst_i = 1'b1;
  logic         start_i = 1'b0;
  logic [127:0] plaintext_i = '0;
  logic         abort_i = 1'b0;
  logic         rk_valid_i = 1'b0;
  logic [127:0] rk_i = '0;
  logic         stage_done_i = 1'b0;
  logic [127:0] stage_state_i = '0;
  logic         ready_o, busy_o, done_o, err_o;
  logic [127:0] ciphertext_o;
  logic         rk_req_o;
  logic [3:0]   rk_idx_o;
  logic         stage_en_o, stage_hold_o, stage_rst_n_o;
  logic         zero_round_o, final_round_o;
  logic [127:0] stage_state_o, stage_key_o;

  aes_round_sequencer dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i),
    .plaintext_i(plaintext_i), .ready_o(ready_o), .busy_o(busy_o),
    .done_o(done_o), .ciphertext_o(ciphertext_o), .abort_i(abort_i),
    .err_o(err_o), .rk_req_o(rk_req_o), .rk_idx_o(rk_idx_o),
    .rk_valid_i(rk_valid_i), .rk_i(rk_i), .stage_en_o(stage_en_o),
    .stage_hold_o(stage_hold_o), .stage_rst_n_o(stage_rst_n_o),
    .zero_round_o(zero_round_o), .final_round_o(final_round_o),
    .stage_state_o(stage_state_o), .stage_key_o(stage_key_o),
    .stage_done_i(stage_done_i), .stage_state_i(stage_state_i)
  );

  always #5 clk = ~clk;

  localparam logic [127:0] KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [127:0] got,
                     input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // ---------------- AES reference pieces ----------------
  logic [7:0]   sbox [256];
  logic [127:0] rkey [11];

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
  endfunction

  function automatic logic [127:0] aes_rnd(input logic [127:0] s,
      input logic [127:0] k, input logic z, input logic f);
    logic [7:0] b [16];
    logic [7:0] t [16];
    logic [7:0] a0, a1, a2, a3;
    logic [127:0] o;
    if (z) return s ^ k;
    for (int i = 0; i < 16; i++) b[i] = sbox[s[127-8*i -: 8]];
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) t[r+4*c] = b[r+4*((c+r)%4)];
    if (!f) begin
      for (int c = 0; c < 4; c++) begin
        a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
        t[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
        t[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
        t[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
        t[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
      end
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = t[i];
    return o ^ k;
  endfunction

  task automatic build_tables();
    logic [7:0] inv, b;
    logic [31:0] w [44];
    logic [31:0] tmp;
    logic [7:0] rc;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      b = inv;
      sbox[x] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^
                {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    end
    for (int i = 0; i < 4; i++) w[i] = KEY[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = subw({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int r = 0; r < 11; r++)
      rkey[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // ---------------- environment models ----------------
  int stg_d = 4;
  int key_dly = 0;
  int scnt = 0;
  int kwait = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int done_cyc = 0;
  int ndone = 0;
  int nlog = 0;
  int unstable = 0;
  int idx_log [64];
  logic hold_valid = 1'b0;
  logic [3:0] hold_idx = '0;
  logic [127:0] done_ct = '0;

  always @(posedge clk) begin
    if (rk_req_o === 1'b1 && rk_valid_i) begin
      if (nlog < 64) idx_log[nlog] = int'(rk_idx_o);
      nlog++;
    end
    if (rk_req_o === 1'b1 && hold_valid && rk_idx_o != hold_idx) unstable++;
    hold_valid = (rk_req_o === 1'b1) && !rk_valid_i;
    hold_idx = rk_idx_o;
    if (done_o === 1'b1) begin
      ndone++;
      done_cyc = cyc;
      done_ct = ciphertext_o;
    end
    if (start_i && ready_o === 1'b1 && !abort_i && !rst_i) acc_cyc = cyc;
    cyc++;
    #1;
    if (rk_req_o === 1'b1) begin
      rk_valid_i = (kwait >= key_dly);
      rk_i = rkey[rk_idx_o];
      kwait++;
    end else begin
      rk_valid_i = 1'b0;
      kwait = 0;
    end
    if (stage_en_o === 1'b1) begin
      scnt++;
      stage_done_i = (scnt == stg_d);
      stage_state_i = aes_rnd(stage_state_o, stage_key_o,
                              zero_round_o, final_round_o);
    end else begin
      scnt = 0;
      stage_done_i = 1'b0;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic start_enc(input logic [127:0] pt);
    @(negedge clk);
    start_i = 1'b1;
    plaintext_i = pt;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic wait_done(input int n0);
    for (int i = 0; i < 3000 && ndone <= n0; i++) @(negedge clk);
    chk("done_seen", 128'(ndone > n0), 128'd1);
  endtask

  task automatic chk_reset_outs();
    chk("rst_ready", 128'(ready_o), 128'd1);
    chk("rst_busy", 128'(busy_o), 128'd0);
    chk("rst_done", 128'(done_o), 128'd0);
    chk("rst_ct", ciphertext_o, 128'd0);
    chk("rst_err", 128'(err_o), 128'd0);
    chk("rst_ctl", {rk_req_o, stage_en_o, stage_hold_o,
                    zero_round_o, final_round_o, stage_rst_n_o}, 128'd0);
    chk("rst_sstate", stage_state_o, 128'd0);
    chk("rst_skey", stage_key_o, 128'd0);
  endtask

  task automatic chk_idx_seq(input string tag);
    chk(tag, 128'(nlog), 128'd11);
    for (int i = 0; i < 11; i++) chk(tag, 128'(idx_log[i]), 128'(i));
  endtask

  int n0;

  initial begin
    build_tables();
    rst_i = 1'b1;
    repeat (2) @(negedge clk);
    chk_reset_outs();
    rst_i = 1'b0;
    #1;
    chk("rstn_after", 128'(stage_rst_n_o), 128'd0);
    @(negedge clk);
    chk("rstn_release", 128'(stage_rst_n_o), 128'd1);

    // FIPS-197 C.1, D=4, keys without stall
    stg_d = 4; key_dly = 0; nlog = 0; n0 = ndone;
    start_enc(PT);
    chk("busy_run", 128'(busy_o), 128'd1);
    wait_done(n0);
    chk("c1_lat", 128'(done_cyc - acc_cyc), 128'd67);
    chk("c1_ct", done_ct, CT);
    chk_idx_seq("c1_idx");
    @(negedge clk);
    chk("c1_ready", 128'(ready_o), 128'd1);

    // keys delayed by 3 cycles each round
    key_dly = 3; nlog = 0; unstable = 0; n0 = ndone;
    start_enc(PT);
    wait_done(n0);
    chk("kd_lat", 128'(done_cyc - acc_cyc), 128'd100);
    chk("kd_ct", done_ct, CT);
    chk_idx_seq("kd_idx");
    chk("kd_stable", 128'(unstable), 128'd0);
    key_dly = 0;

    // start pulsed during round 5 is ignored
    n0 = ndone;
    start_enc(PT);
    for (int i = 0; i < 200 && !(stage_en_o && rk_idx_o == 4'd5); i++)
      @(negedge clk);
    chk("r5_seen", 128'(stage_en_o && rk_idx_o == 4'd5), 128'd1);
    start_i = 1'b1;
    plaintext_i = '1;
    @(negedge clk);
    start_i = 1'b0;
    wait_done(n0);
    repeat (100) @(negedge clk);
    chk("ign_ndone", 128'(ndone - n0), 128'd1);
    chk("ign_ct", done_ct, CT);

    // start together with abort in IDLE
    @(negedge clk);
    start_i = 1'b1;
    abort_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    abort_i = 1'b0;
    chk("sa_ready", 128'(ready_o), 128'd1);
    chk("sa_busy", 128'(busy_o), 128'd0);

    // abort in CAPTURE of round 10
    n0 = ndone;
    start_enc(128'h0);
    for (int i = 0; i < 300 &&
         !(stage_hold_o && !stage_en_o && rk_idx_o == 4'd10); i++)
      @(negedge clk);
    chk("cap10_seen", 128'(stage_hold_o && !stage_en_o), 128'd1);
    abort_i = 1'b1;
    @(negedge clk);
    abort_i = 1'b0;
    chk("ab_ready", 128'(ready_o), 128'd1);
    chk("ab_rstn", 128'(stage_rst_n_o), 128'd0);
    chk("ab_done", 128'(done_o), 128'd0);
    chk("ab_ct", ciphertext_o, CT);
    @(negedge clk);
    chk("ab_rstn_rel", 128'(stage_rst_n_o), 128'd1);
    repeat (5) @(negedge clk);
    chk("ab_ndone", 128'(ndone - n0), 128'd0);

    // reset in ROUND of round 3, then a clean run
    n0 = ndone;
    start_enc(PT);
    for (int i = 0; i < 200 && !(stage_en_o && rk_idx_o == 4'd3); i++)
      @(negedge clk);
    chk("r3_seen", 128'(stage_en_o && rk_idx_o == 4'd3), 128'd1);
    rst_i = 1'b1;
    @(negedge clk);
    chk_reset_outs();
    rst_i = 1'b0;
    repeat (3) @(negedge clk);
    chk("mr_ndone", 128'(ndone - n0), 128'd0);
    start_enc(PT);
    wait_done(n0);
    chk("mr_lat", 128'(done_cyc - acc_cyc), 128'd67);
    chk("mr_ct", done_ct, CT);

    // stage never completes
    stg_d = 100000;
    start_enc(PT);
    repeat (80) @(negedge clk);
`ifdef AES_SEQ_TIMEOUT_EN
    chk("to_err", 128'(err_o), 128'd1);
    chk("to_ready", 128'(ready_o), 128'd1);
`else
    chk("to_busy", 128'(busy_o), 128'd1);
    chk("to_err", 128'(err_o), 128'd0);
`endif
    abort_i = 1'b1;
    @(negedge clk);
    abort_i = 1'b0;
    chk("to_idle", 128'(ready_o), 128'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
